truth_table_prober: RTL and testbench
=====================================

// Module: truth_table_prober
// PURPOSE
//  Characterises a combinational N-input logic gate by exercising all 2**N input rows and sampling its output.
//  Assembles the result into the gate's truth-table hex code, e.g. 8'h50 for a 3-input gate.
//  Sits on the bench/emulation side of the gate library and reads back what a gate module implements.
//  Rows are driven as {in1,in2,...} = row index; row 0 maps to code MSB.
// PARAMETERS
//  N_IN           3   number of gate inputs (legal 2..4)
//  SETTLE_CYCLES  4   cycles to wait after changing dut_in before sampling (>=1)
//  SAMPLES        3   cycles dut_out is sampled per row; majority vote (odd, >=1)
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          asynchronous, active-high reset
//  start     in   1          begin a characterisation run (accepted only in IDLE)
//  busy      out  1          run in progress
//  done      out  1          one-cycle pulse: code/unstable valid
//  dut_in    out  N_IN       drives {in1..inN}; dut_in[N_IN-1] = in1
//  dut_out   in   1          gate output under test
//  code      out  2**N_IN    truth-table code; bit [2**N_IN-1-row] = result for row
//  unstable  out  2**N_IN    per-row disagreement flags (same bit mapping as code)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0, dut_in=0, code=0, unstable=0, all counters=0.
//  FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
//  IDLE: start=1 at edge t0 -> SETTLE at t0+1.
//   - Same edge: row=0, dut_in=0, code=0, unstable=0, busy=1.
//  SETTLE: counts SETTLE_CYCLES cycles; dut_out is ignored; then -> SAMPLE.
//  SAMPLE: for SAMPLES cycles, ones_cnt += dut_out.
//   - On the last sample edge: bit = (2*ones_cnt > SAMPLES) -> written to code[2**N_IN-1-row]; ones_cnt cleared.
//   - If row < 2**N_IN-1: row+1, dut_in=row+1, -> SETTLE.
//   - Else: -> DONE.
//  DONE: exactly one cycle, done=1, busy=0; -> IDLE.
//  Timing: done is high in cycle t0+1+2**N_IN*(SETTLE_CYCLES+SAMPLES), i.e. t0+57 at defaults.
//  dut_in changes only on row-advance edges; it holds the last row (all ones) after the run until the next start.
//  code/unstable hold their values after done until the next accepted start or reset.
//  start while busy or in DONE: ignored. A start held high continuously restarts from IDLE on the cycle after DONE.
//  Counter widths: sized by $clog2 of max+1.
//  Majority uses the full count; no overflow is possible.
// CONFIGURATION
//  Macro TTP_STABILITY_CHECK_EN:
//   - Defined: unstable[bit] = 1 when 0 < ones_cnt < SAMPLES for that row. Written on the same edge as code.
//   - Not defined: unstable is tied to 0. No counter logic is added for it. code behaviour is identical.
// TESTING
//  1. Gate model = 8'h50 truth table, defaults, start pulse at t0
//     -> dut_in steps 0..7, done at t0+57, code=8'h50, unstable=8'h00.
//  2. dut_out tied 0, then tied 1 -> code=8'h00 then 8'hFF; two runs, two done pulses.
//  3. Row 3 (3'b011) dut_out = 1,0,1 across its three samples
//     -> code bit4=1; unstable=8'h10 with TTP_STABILITY_CHECK_EN, 8'h00 without.
//  4. rst asserted mid-run while dut_in=5 -> outputs 0 immediately (async), FSM in IDLE;
//     new start yields the correct code.
//  5. start pulsed while busy at rows 2 and 6 -> ignored. One done only; code unaffected.
//  6. N_IN=2, SETTLE_CYCLES=1, SAMPLES=1, XOR model -> code=4'b0110, done at t0+9.

Source files
------------

// File: rtl/truth_table_prober.sv
// Truth-table prober: steps a gate through all 2**N_IN input rows and majority-votes its output into a hex code.
// Optional per-row stability flags are built only when TTP_STABILITY_CHECK_EN is defined.
module truth_table_prober #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLES       = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic [2**N_IN-1:0]   code,
    output logic [2**N_IN-1:0]   unstable
);
    localparam int ROWS  = 2 ** N_IN;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_d, state_q;
    logic [N_IN-1:0]   row_d, row_q;
    logic [SET_W-1:0]  set_cnt_d, set_cnt_q;
    logic [SMP_W-1:0]  smp_cnt_d, smp_cnt_q;
    logic [SMP_W-1:0]  ones_cnt_d, ones_cnt_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic [ROWS-1:0]   code_d, code_q;

    logic [SMP_W-1:0]  ones_tot_s;
    logic              last_set_s;
    logic              last_smp_s;
    logic              last_row_s;
    logic              row_bit_s;
    logic [N_IN-1:0]   bit_idx_s;

    // Majority over the full count including the sample taken this cycle.
    function automatic logic majority(input logic [SMP_W-1:0] ones);
        return ({1'b0, ones, 1'b0} > (SMP_W + 2)'(SAMPLES));
    endfunction

    assign ones_tot_s = ones_cnt_q + SMP_W'(dut_out);
    assign last_set_s = (set_cnt_q == SET_W'(SETTLE_CYCLES - 1));
    assign last_smp_s = (smp_cnt_q == SMP_W'(SAMPLES - 1));
    assign last_row_s = (row_q == N_IN'(ROWS - 1));
    assign bit_idx_s  = N_IN'(ROWS - 1) - row_q;
    assign row_bit_s  = majority(ones_tot_s);

    // Next-state logic for the row sweep and result assembly.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        set_cnt_d  = set_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        ones_cnt_d = ones_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        code_d     = code_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    row_d      = {N_IN{1'b0}};
                    set_cnt_d  = {SET_W{1'b0}};
                    smp_cnt_d  = {SMP_W{1'b0}};
                    ones_cnt_d = {SMP_W{1'b0}};
                    busy_d     = 1'b1;
                    code_d     = {ROWS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (last_set_s) begin
                    set_cnt_d = {SET_W{1'b0}};
                    state_d   = ST_SAMPLE;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (last_smp_s) begin
                    smp_cnt_d         = {SMP_W{1'b0}};
                    ones_cnt_d        = {SMP_W{1'b0}};
                    code_d[bit_idx_s] = row_bit_s;
                    if (!last_row_s) begin
                        row_d   = row_q + N_IN'(1);
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    smp_cnt_d  = smp_cnt_q + SMP_W'(1);
                    ones_cnt_d = ones_tot_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            row_q      <= {N_IN{1'b0}};
            set_cnt_q  <= {SET_W{1'b0}};
            smp_cnt_q  <= {SMP_W{1'b0}};
            ones_cnt_q <= {SMP_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            code_q     <= {ROWS{1'b0}};
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            set_cnt_q  <= set_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            code_q     <= code_d;
        end
    end

    // The row counter doubles as the gate stimulus, so dut_in holds the last row after a run.
    assign busy   = busy_q;
    assign done   = done_q;
    assign dut_in = row_q;
    assign code   = code_q;

`ifdef TTP_STABILITY_CHECK_EN
    logic [ROWS-1:0] unstable_d, unstable_q;

    function automatic logic disagree(input logic [SMP_W-1:0] ones);
        return (ones != {SMP_W{1'b0}}) && (ones != SMP_W'(SAMPLES));
    endfunction

    // Flag rows whose samples did not all agree, written alongside the code bit.
    always_comb begin
        unstable_d = unstable_q;
        if (state_q == ST_IDLE && start) begin
            unstable_d = {ROWS{1'b0}};
        end else if (state_q == ST_SAMPLE && last_smp_s) begin
            unstable_d[bit_idx_s] = disagree(ones_tot_s);
        end else begin
            unstable_d = unstable_q;
        end
    end

    // Stability flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unstable_q <= {ROWS{1'b0}};
        end else begin
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = {ROWS{1'b0}};
`endif

endmodule

// File: tb/tb_truth_table_prober.sv
// Bench for truth_table_prober: timeline-based reference model checked every cycle, plus literal
// expectations for the directed scenarios; honours TTP_STABILITY_CHECK_EN when it is defined.
module tb_truth_table_prober;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start3 = 1'b0;
    logic       dut_out3 = 1'b0;
    logic       busy3, done3;
    logic [2:0] dut_in3;
    logic [7:0] code3, unstable3;

    logic       start2 = 1'b0;
    logic       dut_out2 = 1'b0;
    logic       busy2, done2;
    logic [1:0] dut_in2;
    logic [3:0] code2, unstable2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit cmp_en = 1'b0;

    int         mode = 0;
    logic [7:0] tt = 8'h00;

    // Reference model: position in the run is edges since the accepting edge (7 edges per row).
    int         m_k = -1;
    int         m_ones [8];
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_row = 3'd0;
    logic [7:0] m_code = 8'h00;
    logic [7:0] m_unst = 8'h00;

    truth_table_prober u3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
        .dut_in(dut_in3), .dut_out(dut_out3), .code(code3), .unstable(unstable3)
    );

    truth_table_prober #(.N_IN(2), .SETTLE_CYCLES(1), .SAMPLES(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .dut_in(dut_in2), .dut_out(dut_out2), .code(code2), .unstable(unstable2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k = -1; m_busy = 1'b0; m_done = 1'b0; m_row = 3'd0;
            m_code = 8'h00; m_unst = 8'h00;
        end else if (m_k < 0) begin
            m_done = 1'b0;
            if (start3) begin
                m_k = 0; m_busy = 1'b1; m_row = 3'd0; m_code = 8'h00; m_unst = 8'h00;
                for (int i = 0; i < 8; i++) m_ones[i] = 0;
            end
        end else begin
            int r, p;
            m_k++;
            r = (m_k - 1) / 7;
            p = (m_k - 1) % 7;
            if (m_k == 57) begin
                m_k = -1;
                m_done = 1'b0;
            end else if (p >= 4) begin
                m_ones[r] += int'(dut_out3);
                if (p == 6) begin
                    m_code[7 - r] = (2 * m_ones[r] > 3);
                    m_unst[7 - r] = (m_ones[r] > 0) && (m_ones[r] < 3);
                    if (r < 7) m_row = 3'(r + 1);
                    else begin
                        m_done = 1'b1;
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (done3) done_cnt++;
        if (cmp_en) begin
            logic [7:0] exp_unst;
`ifdef TTP_STABILITY_CHECK_EN
            exp_unst = m_unst;
`else
            exp_unst = 8'h00;
`endif
            chk("busy", 32'(busy3), 32'(m_busy));
            chk("done", 32'(done3), 32'(m_done));
            chk("dut_in", 32'(dut_in3), 32'(m_row));
            chk("code", 32'(code3), 32'(m_code));
            chk("unstable", 32'(unstable3), 32'(exp_unst));
        end
    end

    // Gate stimulus for both probers.
    initial begin
        forever begin
            @(negedge clk);
            dut_out2 = ^dut_in2;
            case (mode)
                1: dut_out3 = tt[7 - int'(dut_in3)] ^ ($urandom_range(0, 3) == 0);
                2: begin
                    if (m_k >= 0 && m_k / 7 == 3 && m_k % 7 >= 4) dut_out3 = (m_k % 7 != 5);
                    else dut_out3 = tt[7 - int'(dut_in3)];
                end
                default: dut_out3 = tt[7 - int'(dut_in3)];
            endcase
        end
    end

    task automatic pulse3();
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
    endtask

    task automatic wait_done3(input string nm);
        int n = 0;
        while (done3 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done3), 32'd1);
    endtask

    task automatic wait_row3(input logic [2:0] row, input string nm);
        int n = 0;
        while (dut_in3 !== row && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_row_seen"}, 32'(dut_in3), 32'(row));
    endtask

    initial begin
        int t0, dc0;
        logic [7:0] exp_u3;
`ifdef TTP_STABILITY_CHECK_EN
        exp_u3 = 8'h10;
`else
        exp_u3 = 8'h00;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_code", 32'(code3), 32'h00);
        chk("rst_dut_in", 32'(dut_in3), 32'd0);
        cmp_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // Known gate 8'h50: code and done latency.
        tt = 8'h50; mode = 0;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0; t0 = cyc;
        wait_done3("t1");
        chk("t1_done_time", 32'(cyc - t0), 32'd56);
        chk("t1_code", 32'(code3), 32'h50);
        chk("t1_unstable", 32'(unstable3), 32'h00);
        @(negedge clk);
        chk("t1_hold_code", 32'(code3), 32'h50);

        // Constant 0 then constant 1, with start held high across the first DONE.
        tt = 8'h00; dc0 = done_cnt;
        @(negedge clk); start3 = 1'b1;
        wait_done3("t2a");
        chk("t2_code0", 32'(code3), 32'h00);
        tt = 8'hFF;
        @(negedge clk);
        @(negedge clk); start3 = 1'b0;
        @(negedge clk);
        wait_done3("t2b");
        chk("t2_code1", 32'(code3), 32'hFF);
        @(negedge clk);
        chk("t2_done_pulses", 32'(done_cnt - dc0), 32'd2);

        // Row 3 sees 1,0,1.
        tt = 8'h50; mode = 2;
        pulse3();
        wait_done3("t3");
        chk("t3_code", 32'(code3), 32'h50);
        chk("t3_unstable", 32'(unstable3), 32'(exp_u3));
        @(negedge clk);
        mode = 0;

        // Asynchronous reset mid-run at row 5.
        pulse3();
        wait_row3(3'd5, "t4");
        chk("t4_partial_code", 32'(code3), 32'h50);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_busy", 32'(busy3), 32'd0);
        chk("t4_rst_dut_in", 32'(dut_in3), 32'd0);
        chk("t4_rst_code", 32'(code3), 32'h00);
        chk("t4_rst_unstable", 32'(unstable3), 32'h00);
        @(negedge clk); rst = 1'b0;
        tt = 8'hA5;
        pulse3();
        wait_done3("t4b");
        chk("t4_code", 32'(code3), 32'hA5);
        @(negedge clk);

        // Start pulses while busy are ignored.
        tt = 8'h3C; dc0 = done_cnt;
        pulse3();
        wait_row3(3'd2, "t5a");
        pulse3();
        wait_row3(3'd6, "t5b");
        pulse3();
        wait_done3("t5");
        chk("t5_code", 32'(code3), 32'h3C);
        repeat (10) @(negedge clk);
        chk("t5_done_pulses", 32'(done_cnt - dc0), 32'd1);
        chk("t5_idle_busy", 32'(busy3), 32'd0);

        // Random gates with sample noise.
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            tt = 8'($urandom);
            pulse3();
            wait_done3("rnd");
            @(negedge clk);
        end
        mode = 0;

        // Two-input XOR, minimal timing.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("t6_dut_in", 32'(dut_in2), 32'((k / 2 > 3) ? 3 : k / 2));
            chk("t6_done", 32'(done2), 32'(k == 8));
            if (k == 8) chk("t6_code", 32'(code2), 32'h6);
        end
        chk("t6_unstable", 32'(unstable2), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
